// File: rtl/prbs_checker.sv
// PRBS-15 (x^15+x^14+1) receive checker: hunt/verify/locked acquisition with windowed loss-of-lock.
// Define PRBS_CHECKER_STATS_EN to build the BIT_COUNT/ERR_COUNT statistics counters.
module prbs_checker #(
  parameter int SYNC_LEN    = 32,
  parameter int WINDOW_LEN  = 1024,
  parameter int LOSS_THRESH = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DATA_IN,
  input  logic        DATA_IN_VALID,
  input  logic        CLEAR_COUNTERS,
  output logic        LOCK,
  output logic        ERR_PULSE,
  output logic [31:0] BIT_COUNT,
  output logic [31:0] ERR_COUNT
);

  localparam int MW = $clog2(SYNC_LEN + 1);
  localparam int WW = $clog2(WINDOW_LEN + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);
  localparam logic [MW-1:0] SYNC_LAST = MW'(SYNC_LEN - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW_LEN - 1);
  localparam logic [EW-1:0] LOSS_CNT  = EW'(LOSS_THRESH);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [14:0]   lfsr_q, lfsr_d;
  logic [3:0]    load_cnt_q, load_cnt_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [WW-1:0] win_bit_q, win_bit_d;
  logic [EW-1:0] win_err_q, win_err_d, win_err_inc;
  logic          lock_q, lock_d;
  logic          err_pulse_q, err_pulse_d;
  logic          exp_bit, bit_err;

  assign exp_bit     = lfsr_q[14] ^ lfsr_q[13];
  assign bit_err     = DATA_IN ^ exp_bit;
  assign win_err_inc = win_err_q + EW'(bit_err);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    load_cnt_d  = load_cnt_q;
    match_cnt_d = match_cnt_q;
    win_bit_d   = win_bit_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    if (DATA_IN_VALID) begin
      case (state_q)
        HUNT: begin
          lfsr_d = {lfsr_q[13:0], DATA_IN};
          if (load_cnt_q == 4'd14) begin
            load_cnt_d  = '0;
            match_cnt_d = '0;
            state_d     = VERIFY;
          end else begin
            load_cnt_d = load_cnt_q + 4'd1;
          end
        end
        VERIFY: begin
          lfsr_d = {lfsr_q[13:0], exp_bit};
          if (bit_err) begin
            state_d     = HUNT;
            load_cnt_d  = '0;
            match_cnt_d = '0;
          end else if (match_cnt_q == SYNC_LAST) begin
            state_d     = LOCKED;
            match_cnt_d = '0;
            win_bit_d   = '0;
            win_err_d   = '0;
          end else begin
            match_cnt_d = match_cnt_q + MW'(1);
          end
        end
        LOCKED: begin
          // Free-running reference: one channel error shows up as exactly one errored bit.
          lfsr_d      = {lfsr_q[13:0], exp_bit};
          err_pulse_d = bit_err;
          // Threshold test uses the count including this bit, ahead of the window wrap.
          if (win_err_inc == LOSS_CNT) begin
            state_d    = HUNT;
            load_cnt_d = '0;
            win_bit_d  = '0;
            win_err_d  = '0;
          end else if (win_bit_q == WIN_LAST) begin
            win_bit_d = '0;
            win_err_d = '0;
          end else begin
            win_bit_d = win_bit_q + WW'(1);
            win_err_d = win_err_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= HUNT;
      lfsr_q      <= '0;
      load_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_bit_q   <= '0;
      win_err_q   <= '0;
      lock_q      <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      load_cnt_q  <= load_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_bit_q   <= win_bit_d;
      win_err_q   <= win_err_d;
      lock_q      <= lock_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign LOCK      = lock_q;
  assign ERR_PULSE = err_pulse_q;

`ifdef PRBS_CHECKER_STATS_EN
  logic [31:0] bit_count_q, bit_count_d;
  logic [31:0] err_count_q, err_count_d;
  logic        chk_locked;

  assign chk_locked = DATA_IN_VALID && (state_q == LOCKED);

  always_comb begin
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;
    if (CLEAR_COUNTERS) begin
      bit_count_d = '0;
      err_count_d = '0;
    end else if (chk_locked) begin
      if (bit_count_q != '1)            bit_count_d = bit_count_q + 32'd1;
      if (bit_err && err_count_q != '1) err_count_d = err_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign BIT_COUNT = bit_count_q;
  assign ERR_COUNT = err_count_q;
`else
  logic unused_clear;
  assign unused_clear = CLEAR_COUNTERS;
  assign BIT_COUNT    = '0;
  assign ERR_COUNT    = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: acquisition, error injection, window loss, relock, clear, reset.
module tb_prbs_checker;

`ifdef PRBS_CHECKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        DATA_IN = 1'b0;
  logic        DATA_IN_VALID = 1'b0;
  logic        CLEAR_COUNTERS = 1'b0;
  logic        LOCK, ERR_PULSE;
  logic [31:0] BIT_COUNT, ERR_COUNT;

  prbs_checker dut (
    .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .DATA_IN_VALID(DATA_IN_VALID),
    .CLEAR_COUNTERS(CLEAR_COUNTERS), .LOCK(LOCK), .ERR_PULSE(ERR_PULSE),
    .BIT_COUNT(BIT_COUNT), .ERR_COUNT(ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  logic prbs [0:8191];
  int   p = 0;
  int   checks = 0, passes = 0, fails = 0;

  function automatic logic [31:0] cexp(input logic [31:0] v);
    return STATS ? v : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: valid bits take the next stream bit (optionally inverted); idle cycles carry garbage.
  task automatic send(input logic inv, input logic v, input logic clr);
    DATA_IN        = v ? (prbs[p] ^ inv) : ~prbs[p];
    DATA_IN_VALID  = v;
    CLEAR_COUNTERS = clr;
    @(posedge CLK); #1;
    if (v) p++;
    DATA_IN_VALID  = 1'b0;
    CLEAR_COUNTERS = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    send(1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
  endtask

  initial begin
    int early, pulses, pmis;
    logic inv;

    for (int i = 0; i < 15; i++) prbs[i] = (i == 0);
    for (int i = 15; i < 8192; i++) prbs[i] = prbs[i-15] ^ prbs[i-14];

    // Reset state
    do_reset();
    chk("rst_lock", {31'd0, LOCK}, 0);
    chk("rst_pulse", {31'd0, ERR_PULSE}, 0);
    chk("rst_bitcnt", BIT_COUNT, 0);
    chk("rst_errcnt", ERR_COUNT, 0);

    // Clean acquisition: lock visible right after the 47th bit
    early = 0;
    for (int i = 1; i <= 46; i++) begin
      send(1'b0, 1'b1, 1'b0);
      if (LOCK) early++;
    end
    chk("acq_no_early_lock", early, 0);
    send(1'b0, 1'b1, 1'b0);
    chk("acq_lock_bit47", {31'd0, LOCK}, 1);

    // 1000 clean locked bits
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      send(1'b0, 1'b1, 1'b0);
      pulses += int'(ERR_PULSE);
    end
    chk("clean_pulses", pulses, 0);
    chk("clean_bitcnt", BIT_COUNT, cexp(1000));
    chk("clean_errcnt", ERR_COUNT, 0);

    // Three isolated errors in 1000 bits
    pulses = 0; pmis = 0; early = 0;
    for (int i = 0; i < 1000; i++) begin
      inv = (i == 100 || i == 400 || i == 800);
      send(inv, 1'b1, 1'b0);
      pulses += int'(ERR_PULSE);
      if (ERR_PULSE !== inv) pmis++;
      if (!LOCK) early++;
    end
    chk("iso_pulse_count", pulses, 3);
    chk("iso_pulse_align", pmis, 0);
    chk("iso_lock_held", early, 0);
    chk("iso_errcnt", ERR_COUNT, cexp(3));
    chk("iso_bitcnt", BIT_COUNT, cexp(2000));

    // Clear with a simultaneous valid bit: not counted, lock untouched
    send(1'b0, 1'b1, 1'b1);
    chk("clr_bitcnt", BIT_COUNT, 0);
    chk("clr_errcnt", ERR_COUNT, 0);
    chk("clr_lock", {31'd0, LOCK}, 1);

    // Align to the next window start (locked bit 2048), then 15 errors early and the 16th on the last bit
    for (int i = 0; i < 47; i++) send(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 1023; i++) send((i < 30) && (i % 2 == 0), 1'b1, 1'b0);
    chk("win_lock_before_last", {31'd0, LOCK}, 1);
    send(1'b1, 1'b1, 1'b0);
    chk("win_lock_lost", {31'd0, LOCK}, 0);
    chk("win_last_pulse", {31'd0, ERR_PULSE}, 1);
    chk("win_errcnt", ERR_COUNT, cexp(16));
    chk("win_bitcnt", BIT_COUNT, cexp(1071));

    // Relock after 47 clean bits; counters frozen outside LOCKED
    early = 0;
    for (int i = 1; i <= 46; i++) begin
      send(1'b0, 1'b1, 1'b0);
      if (LOCK) early++;
    end
    chk("relock_no_early", early, 0);
    chk("relock_bitcnt_frozen", BIT_COUNT, cexp(1071));
    send(1'b0, 1'b1, 1'b0);
    chk("relock_lock", {31'd0, LOCK}, 1);

    // 15 errors at the tail of a window, one more just after the wrap: lock must hold
    early = 0;
    for (int i = 0; i < 1026; i++) begin
      send(((i >= 994) && (i <= 1022) && (i % 2 == 0)) || (i == 1025), 1'b1, 1'b0);
      if (!LOCK) early++;
    end
    chk("wrap_lock_held", early, 0);
    chk("wrap_errcnt", ERR_COUNT, cexp(32));
    chk("wrap_bitcnt", BIT_COUNT, cexp(2097));

    // Reset mid-LOCKED with an errored valid bit and a clear request
    RESET = 1'b1;
    send(1'b1, 1'b1, 1'b1);
    RESET = 1'b0;
    chk("midrst_lock", {31'd0, LOCK}, 0);
    chk("midrst_pulse", {31'd0, ERR_PULSE}, 0);
    chk("midrst_bitcnt", BIT_COUNT, 0);
    chk("midrst_errcnt", ERR_COUNT, 0);

    // Mismatch on the 20th verify bit drops back to hunt
    early = 0;
    for (int i = 0; i < 34; i++) begin
      send(1'b0, 1'b1, 1'b0);
      if (LOCK) early++;
    end
    send(1'b1, 1'b1, 1'b0);
    if (LOCK) early++;
    for (int i = 1; i <= 46; i++) begin
      send(1'b0, 1'b1, 1'b0);
      if (LOCK) early++;
    end
    chk("vfail_no_lock", early, 0);
    chk("vfail_bitcnt", BIT_COUNT, 0);
    send(1'b0, 1'b1, 1'b0);
    chk("vfail_relock", {31'd0, LOCK}, 1);

    // 50% valid duty: lock on the same valid-bit index, idle cycles hold everything
    do_reset();
    early = 0;
    for (int i = 1; i <= 46; i++) begin
      send(1'b0, 1'b1, 1'b0);
      send(1'b0, 1'b0, 1'b0);
      if (LOCK) early++;
    end
    chk("duty_no_early", early, 0);
    send(1'b0, 1'b1, 1'b0);
    chk("duty_lock", {31'd0, LOCK}, 1);
    send(1'b0, 1'b0, 1'b0);
    chk("duty_idle_lock", {31'd0, LOCK}, 1);
    chk("duty_idle_pulse", {31'd0, ERR_PULSE}, 0);
    chk("duty_idle_bitcnt", BIT_COUNT, 0);
    send(1'b0, 1'b1, 1'b0);
    chk("duty_bitcnt", BIT_COUNT, cexp(1));
    send(1'b0, 1'b1, 1'b1);
    chk("duty_clr_bitcnt", BIT_COUNT, 0);
    chk("duty_clr_lock", {31'd0, LOCK}, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
